fifo_wr_arbiter: RTL and testbench

Write-side arbiter for the asynchronous FIFO. It shares the single FIFO write port among NREQ requesters using round-robin grants with a bounded burst length. It sits entirely in the write clock domain, directly in front of the write-pointer logic. It drives the FIFO write enable and write data, and honours the registered full flag returned by the write-pointer logic.

---
 rtl/fifo_wr_arbiter_if.sv | 28 ++
 rtl/fifo_wr_arbiter.sv | 132 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester and FIFO write-port bundle
// master drives requests and full, slave is the arbiter
interface fifo_wr_arbiter_if #(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int GW = $clog2(NREQ);

  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_last;
  logic [NREQ*DATA_WIDTH-1:0] req_data;
  logic [NREQ-1:0]            req_ready;
  logic                       full;
  logic                       w_en;
  logic [DATA_WIDTH-1:0]      w_data;
  logic [GW-1:0]              grant_id;
  logic                       busy;

  modport master (
    output req_valid, req_last, req_data, full,
    input  req_ready, w_en, w_data, grant_id, busy
  );

  modport slave (
    input  req_valid, req_last, req_data, full,
    output req_ready, w_en, w_data, grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin write-port arbiter
// with bounded bursts in front of the FIFO write pointer
module fifo_wr_arbiter #(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic            w_clk,
  input  logic            wrst,
  fifo_wr_arbiter_if.slave bus
);
  localparam int GW = $clog2(NREQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [GW:0] NREQ_W = (GW+1)'(NREQ);
  localparam logic [GW-1:0] LAST_ID = GW'(NREQ - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [GW-1:0]   r_rr_ptr;
  logic [GW-1:0]   w_rr_ptr_nxt;
  logic [GW-1:0]   r_grant_id;
  logic [GW-1:0]   w_grant_nxt;
  logic [BW-1:0]   r_beat_cnt;
  logic [BW-1:0]   w_beat_nxt;

  logic            w_found;
  logic [GW-1:0]   w_pick;
  logic [GW:0]     w_sum;
  logic [GW-1:0]   w_idx;
  logic            w_cur_valid;
  logic            w_cur_last;
  logic            w_xfer;
  logic [GW-1:0]   w_next_id;
  logic [DATA_WIDTH-1:0] w_words [NREQ];

  // unpack requester words so the data mux is a plain index
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      w_words[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // first valid requester at or after rr_ptr, wrapping at NREQ
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_rr_ptr;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (GW+1)'(k);
      if (w_sum >= NREQ_W) begin
        w_sum = w_sum - NREQ_W;
      end
      w_idx = w_sum[GW-1:0];
      if (!w_found && bus.req_valid[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  assign w_cur_valid = bus.req_valid[r_grant_id];
  assign w_cur_last  = bus.req_last[r_grant_id];
  assign w_xfer      = (r_state == GRANT)
                     & w_cur_valid & ~bus.full;
  assign w_next_id   = (r_grant_id == LAST_ID)
                     ? '0 : r_grant_id + 1'b1;

  // next state, grant bookkeeping and write-port outputs
  always_comb begin
    w_state_nxt   = r_state;
    w_rr_ptr_nxt  = r_rr_ptr;
    w_grant_nxt   = r_grant_id;
    w_beat_nxt    = r_beat_cnt;
    bus.req_ready = '0;
    bus.w_en      = 1'b0;
    bus.w_data    = w_words[r_grant_id];
    bus.busy      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = GRANT;
          w_grant_nxt = w_pick;
          w_beat_nxt  = '0;
        end
      end
      GRANT: begin
        bus.busy = 1'b1;
        bus.req_ready[r_grant_id] = ~bus.full;
        bus.w_en = w_xfer;
        if (!w_cur_valid) begin
          w_state_nxt  = IDLE;
          w_rr_ptr_nxt = w_next_id;
          w_beat_nxt   = '0;
        end else if (w_xfer) begin
          w_beat_nxt = r_beat_cnt + 1'b1;
          if (w_cur_last || r_beat_cnt == LAST_BEAT) begin
            w_state_nxt  = IDLE;
            w_rr_ptr_nxt = w_next_id;
            w_beat_nxt   = '0;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.grant_id = r_grant_id;

  // state and arbitration registers, synchronous reset
  always_ff @(posedge w_clk) begin
    if (wrst) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_grant_id <= w_grant_nxt;
      r_beat_cnt <= w_beat_nxt;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: random requesters checked
// against a transaction-level arbiter model
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int MB   = 4;

  logic w_clk = 1'b0;
  logic wrst;
  always #5 w_clk = ~w_clk;

  fifo_wr_arbiter_if #(
    .NREQ(NREQ),
    .DATA_WIDTH(DW)
  ) bus ();

  fifo_wr_arbiter #(
    .NREQ(NREQ),
    .DATA_WIDTH(DW),
    .MAX_BURST(MB)
  ) dut (
    .w_clk(w_clk),
    .wrst(wrst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  bit m_busy;
  int m_gid;
  int m_ptr;
  int m_beats;

  logic [DW-1:0] cur_data [NREQ];
  bit            cur_last [NREQ];
  int            wait_cnt [NREQ];
  bit            prev_busy;
  logic [NREQ-1:0] prev_v;
  int            glog [$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h exp %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_gid   = 0;
    m_ptr   = 0;
    m_beats = 0;
    for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
  endtask

  task automatic step(input int vp, input int lp,
                      input int fp, input int rp,
                      input bit log_en);
    bit rst;
    bit en;
    bit last_w;
    bit fl;
    int g;
    int idx;
    int exp_rdy;
    logic [NREQ-1:0] v;
    rst  = ($urandom_range(99) < rp);
    wrst = rst;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i] = ($urandom_range(99) < vp);
      bus.req_last[i]  = cur_last[i];
      bus.req_data[i*DW +: DW] = cur_data[i];
    end
    bus.full = ($urandom_range(99) < fp);
    @(negedge w_clk);
    v  = bus.req_valid;
    fl = bus.full;
    en = m_busy && v[m_gid] && !fl;
    exp_rdy = (m_busy && !fl) ? (1 << m_gid) : 0;
    chk("busy", bus.busy, m_busy);
    chk("grant_id", bus.grant_id, m_gid);
    chk("w_en", bus.w_en, en);
    chk("req_ready", bus.req_ready, exp_rdy);
    if (en) chk("w_data", bus.w_data, cur_data[m_gid]);
    if (bus.busy && !prev_busy) begin
      g = bus.grant_id;
      chk("fair", (wait_cnt[g] < NREQ) ? 1 : 0, 1);
      for (int i = 0; i < NREQ; i++) begin
        if (i == g) wait_cnt[i] = 0;
        else if (prev_v[i]) wait_cnt[i]++;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!v[i]) wait_cnt[i] = 0;
    end
    prev_busy = bus.busy;
    prev_v    = v;
    last_w    = 1'b0;
    if (en) begin
      if (log_en) glog.push_back(m_gid);
      last_w = cur_last[m_gid];
      cur_data[m_gid] = DW'($urandom);
      cur_last[m_gid] = ($urandom_range(99) < lp);
      m_beats++;
    end
    if (rst) begin
      model_reset();
    end else if (!m_busy) begin
      if (v != '0) begin
        for (int k = NREQ - 1; k >= 0; k--) begin
          idx = (m_ptr + k) % NREQ;
          if (v[idx]) m_gid = idx;
        end
        m_busy  = 1'b1;
        m_beats = 0;
      end
    end else if (!v[m_gid] ||
                 (en && (last_w || m_beats == MB))) begin
      m_busy  = 1'b0;
      m_ptr   = (m_gid + 1) % NREQ;
      m_beats = 0;
    end
    @(posedge w_clk);
    #1;
  endtask

  int rr_exp [5] = '{0, 1, 2, 3, 0};

  initial begin
    wrst          = 1'b1;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.full      = 1'b0;
    prev_busy     = 1'b0;
    prev_v        = '0;
    for (int i = 0; i < NREQ; i++) begin
      cur_data[i] = DW'($urandom);
      cur_last[i] = 1'b0;
    end
    model_reset();
    repeat (2) @(posedge w_clk);
    #1;
    step(0, 30, 0, 100, 1'b0);
    step(90, 20, 0, 1, 1'b0);
    repeat (600) step(90, 20, 0, 1, 1'b0);
    repeat (600) step(80, 30, 40, 1, 1'b0);
    repeat (600) step(50, 50, 20, 2, 1'b0);
    repeat (600) step(100, 10, 10, 0, 1'b0);
    repeat (300) step(100, 0, 0, 3, 1'b0);
    for (int i = 0; i < NREQ; i++) cur_last[i] = 1'b1;
    step(100, 100, 0, 100, 1'b0);
    repeat (12) step(100, 100, 0, 0, 1'b1);
    chk("rr_cnt", (glog.size() >= 5) ? 1 : 0, 1);
    for (int k = 0; k < 5; k++) begin
      if (k < glog.size()) chk("rr_order", glog[k], rr_exp[k]);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
